// File: rtl/clmul_ds_seq.sv
// Digit-serial carry-less (GF(2)[x]) multiplier, DIGIT bits of b per cycle, MSB digit first.
// Define CLMUL_GF_REDUCE_EN to add a bit-serial reduction mod x^WIDTH + POLY after the multiply.
module clmul_ds_seq #(
  parameter int              WIDTH = 49,
  parameter int              DIGIT = 7,
  parameter logic [WIDTH-1:0] POLY = 49'h201
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-2:0]   y
);

  localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int BW   = NDIG * DIGIT;
  localparam int YW   = 2 * WIDTH - 1;
  localparam int AW   = YW + DIGIT;
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
`ifdef CLMUL_GF_REDUCE_EN
    S_RED,
`endif
    S_DONE
  } state_t;

`ifdef CLMUL_GF_REDUCE_EN
  localparam logic [AW-1:0] PFULL = AW'({1'b1, POLY});
`else
  logic unused_poly;
  assign unused_poly = ^POLY;
`endif

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [BW-1:0]     b_q, b_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [YW-1:0]     y_q, y_d;
  logic [DIGIT-1:0]  digit;
  logic [AW-1:0]     pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  // WIDTH x DIGIT carry-less partial product of the current digit
  always_comb begin
    digit = b_q[int'(cnt_q) * DIGIT +: DIGIT];
    pp    = '0;
    for (int j = 0; j < DIGIT; j++) begin
      if (digit[j]) pp = pp ^ (AW'(a_q) << j);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = BW'(b);
          acc_d   = '0;
          cnt_d   = CW'(NDIG - 1);
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = (acc_q << DIGIT) ^ pp;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
`ifdef CLMUL_GF_REDUCE_EN
          cnt_d   = CW'(WIDTH - 2);
          state_d = S_RED;
`else
          cnt_d   = '0;
          y_d     = acc_d[YW-1:0];
          state_d = S_DONE;
`endif
        end
      end
`ifdef CLMUL_GF_REDUCE_EN
      // cnt tracks k - WIDTH for the bit k being cleared this cycle
      S_RED: begin
        if (acc_q[int'(cnt_q) + WIDTH]) acc_d = acc_q ^ (PFULL << cnt_q);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = '0;
          y_d     = acc_d[YW-1:0];
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign y         = y_q;

endmodule

// File: tb/tb_clmul_ds_seq.sv
// Directed self-checking bench for clmul_ds_seq (default 49x7 instance plus a padded 10x3 instance).
module tb_clmul_ds_seq;

  localparam int W    = 49;
  localparam int NDIG = 7;
`ifdef CLMUL_GF_REDUCE_EN
  localparam int LAT  = NDIG + W - 1;
`else
  localparam int LAT  = NDIG;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-2:0] y;

  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [9:0]    s_a = '0;
  logic [9:0]    s_b = '0;
  logic          s_out_valid;
  logic          s_out_ready = 1'b1;
  logic [18:0]   s_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clmul_ds_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  clmul_ds_seq #(.WIDTH(10), .DIGIT(3), .POLY(10'h009)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .y(s_y)
  );

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    a = av; b = bv; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL send_accept: in_ready=%b required 1 (timeout)", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [2*W-2:0] yv, output int n);
    logic busy_rdy;
    busy_rdy = 1'b0; n = 0;
    while (!out_valid && n < LAT + 20) begin
      if (in_ready) busy_rdy = 1'b1;
      @(posedge clk); #1; n++;
    end
    if (in_ready) busy_rdy = 1'b1;
    yv = y;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL wait_out_timeout: out_valid=%b required 1 after %0d cycles", out_valid, n);
    end
    checks++;
    if (busy_rdy !== 1'b0) begin
      errors++; $display("FAIL busy_in_ready: in_ready seen %b while busy, required 0", busy_rdy);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++;
    if (y !== '0) begin errors++; $display("FAIL rst_y: got %h want 0", y); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [W-1:0]   va [3] = '{49'h1, 49'h3, 49'h1_FFFF_FFFF_FFFF};
    logic [W-1:0]   vb [3] = '{49'h1, 49'h3, 49'h1};
    logic [2*W-2:0] ve [3] = '{97'h1, 97'h5, 97'h1_FFFF_FFFF_FFFF};
    logic [2*W-2:0] yv;
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(va[i], vb[i]);
      wait_out(yv, n);
      checks++;
      if (yv !== ve[i]) begin errors++; $display("FAIL basic_y[%0d]: got %h want %h", i, yv, ve[i]); end
      checks++;
      if (n !== LAT) begin errors++; $display("FAIL basic_latency[%0d]: got %0d want %0d", i, n, LAT); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL basic_handshake[%0d]: out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_top_bit();
    logic [2*W-2:0] yv;
    logic [2*W-2:0] exp;
    int n;
`ifdef CLMUL_GF_REDUCE_EN
    exp = 97'h201;
    send(49'h1 << 48, 49'h2);
`else
    exp = 97'h1 << 96;
    send(49'h1 << 48, 49'h1 << 48);
`endif
    wait_out(yv, n);
    checks++;
    if (yv !== exp) begin errors++; $display("FAIL top_y: got %h want %h", yv, exp); end
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL top_latency: got %0d want %0d", n, LAT); end
    @(posedge clk); #1;
  endtask

  task automatic test_padded();
    logic [9:0]  va [2] = '{10'h3FF, 10'h201};
    logic [9:0]  vb [2] = '{10'h3FF, 10'h003};
    logic [18:0] ve [2] = '{19'h55555, 19'h00603};
    int n;
    for (int i = 0; i < 2; i++) begin
      s_a = va[i]; s_b = vb[i]; s_in_valid = 1'b1;
      checks++;
      if (s_in_ready !== 1'b1) begin errors++; $display("FAIL pad_ready[%0d]: got %b want 1", i, s_in_ready); end
      @(posedge clk); #1;
      s_in_valid = 1'b0; n = 0;
      while (!s_out_valid && n < 40) begin @(posedge clk); #1; n++; end
      checks++;
      if (s_y !== ve[i]) begin errors++; $display("FAIL pad_y[%0d]: got %h want %h", i, s_y, ve[i]); end
      checks++;
      if (n !== 4) begin errors++; $display("FAIL pad_latency[%0d]: got %0d want 4", i, n); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [2*W-2:0] yv;
    int n;
    out_ready = 1'b0;
    send(49'h5, 49'h7);
    wait_out(yv, n);
    checks++;
    if (yv !== 97'h1B) begin errors++; $display("FAIL bp_y: got %h want 1b", yv); end
    a = 49'h9; b = 49'h9; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || y !== 97'h1B || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: out_valid=%b y=%h in_ready=%b want 1/1b/0", i, out_valid, y, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(yv, n);
    checks++;
    if (yv !== 97'h41) begin errors++; $display("FAIL bp_next_y: got %h want 41", yv); end
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL bp_next_latency: got %0d want %0d", n, LAT); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [2*W-2:0] yv;
    logic seen;
    int n;
    send(49'h6, 49'h3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== '0) begin
      errors++; $display("FAIL midrst_outputs: in_ready=%b out_valid=%b y=%h want 1/0/0", in_ready, out_valid, y);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_stale_valid: got %b want 0", seen); end
    send(49'h6, 49'h3);
    wait_out(yv, n);
    checks++;
    if (yv !== 97'hA) begin errors++; $display("FAIL midrst_y: got %h want a", yv); end
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL midrst_latency: got %0d want %0d", n, LAT); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_top_bit();
`ifndef CLMUL_GF_REDUCE_EN
    test_padded();
`endif
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clmul_ds_seq.md
Name: clmul_ds_seq

Overview:
- Parametrised, digit-serial carry-less (GF(2)[x]) multiplier: successor to the fixed-width combinational Karatsuba multipliers.
- Computes y = a·b over GF(2), with no carries and all partial-product sums as XOR.
- Processes DIGIT bits of b per clock, trading latency for area.
- Valid/ready handshakes on input and output.
- Sits between operand registers and the field-arithmetic datapath.

Parameters:
- WIDTH, 49: operand width in bits (≥2).
- DIGIT, 7: bits of b consumed per compute cycle (1..WIDTH).
- POLY, 49'h201: low WIDTH bits of the reduction polynomial P = x^WIDTH + POLY. Used only with the optional feature. Default gives x^49+x^9+1.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operands valid.
- in_ready, output, 1: block can accept operands.
- a, input, WIDTH: multiplicand polynomial; bit i = coefficient of x^i.
- b, input, WIDTH: multiplier polynomial.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- y, output, 2*WIDTH-1: product polynomial.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, y=0, internal accumulator and digit counter = 0.
- Reset mid-operation aborts the current operation. The result is lost and no out_valid is produced.
- NDIG = ceil(WIDTH/DIGIT). b is zero-extended to NDIG·DIGIT bits.
- FSM states: IDLE, MUL, (RED), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register a and extended b, clear the accumulator, set cnt=NDIG-1, go to MUL.
- MUL (one digit per cycle, MSB digit first, Horner form):
  - acc <= (acc << DIGIT) XOR clmul(a_reg, b_digit[cnt]). clmul is a WIDTH×DIGIT carry-less product, implemented as an AND/XOR array.
  - acc is 2*WIDTH-1+DIGIT bits wide internally. Only the low 2*WIDTH-1 bits are ever non-zero at completion.
  - After the cnt==0 digit: go to RED if the feature is enabled, else DONE.
- DONE:
  - out_valid=1; y = final product, held stable while out_valid && !out_ready.
  - On out_ready: out_valid=0, go to IDLE.
- in_ready is 1 only in IDLE. There is no overlap between operations.
- out_valid can rise at the earliest in the cycle after the last MUL cycle.
- Latency: accept edge to out_valid high = NDIG cycles (7 at defaults) without reduction.
- Throughput: one result per NDIG+2 cycles with out_ready tied high. The extra cycles are DONE and the IDLE accept.
- in_valid while busy is ignored; the upstream holds it.
- Operand changes after acceptance have no effect.
- y only updates on entry to DONE. Between operations it holds the last result.
- DIGIT==WIDTH gives a single-cycle MUL state.
- A DIGIT that does not divide WIDTH is handled by the zero padding.

Optional Feature:
- Macro: CLMUL_GF_REDUCE_EN.
- When defined:
  - State RED performs bitwise modular reduction mod P, one bit per cycle, from degree 2*WIDTH-2 down to WIDTH: WIDTH-1 cycles.
  - Each cycle: if acc[k] is set, acc ^= (x^WIDTH + POLY) << (k-WIDTH).
  - Then go to DONE. y[2*WIDTH-2:WIDTH]=0 and y[WIDTH-1:0] = a·b mod P.
  - Latency becomes NDIG+WIDTH-1 cycles (55 at defaults).
- When undefined: no RED state, POLY is unused, and y is the full unreduced product.

Test Plan:
- Reset, then a=1, b=1, out_ready=1 → out_valid rises exactly 7 cycles after the accept edge; y=1; in_ready low during MUL/DONE.
- a=3, b=3 → y=5 (x²+1, no carry). a=49'h1_FFFF_FFFF_FFFF (all ones), b=1 → y=a.
- a=1<<48, b=1<<48 → y=1<<96, the top bit of y. Repeat with WIDTH=10, DIGIT=3 (NDIG=4, padded): a=10'h3FF, b=10'h3FF → y=19'h55555.
- Backpressure: out_ready=0 for 5 cycles after out_valid → y and out_valid stable, in_ready=0, and a new in_valid is not accepted. Raising out_ready completes the handshake, and the next operand is accepted in IDLE.
- Drive rst_n low during MUL cycle 3 → all outputs at reset values immediately (asynchronous). After release, no stale out_valid; the next operation returns a correct result.
- With CLMUL_GF_REDUCE_EN: a=1<<48, b=2 → y=49'h201 after 55 cycles. Also a=3, b=3 → y=5 (no reduction needed).
